// File: rtl/cat_pkg.sv
// ---------------------------------------------------------------------------
// cat_pkg
// Shared definitions for the cat sprite draw stage.
//   SPRITE_SIZE  : sprite edge length in pixels (address map assumes 64)
//   CAT_FRAMES   : number of animation frames held in the pixel ROM
//   KEY_COLOR    : ROM pixel value that is treated as transparent
//   anim_state_t : animation FSM states
//   vga_if_t     : one beat of the VGA timing/pixel bus
//   sprite_addr  : ROM address for a beam position relative to the sprite
// ---------------------------------------------------------------------------
package cat_pkg;

  localparam int          SPRITE_SIZE = 64;
  localparam int          CAT_FRAMES  = 4;
  localparam logic [11:0] KEY_COLOR   = 12'h0F0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WALK = 1'b1
  } anim_state_t;

  typedef struct packed {
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;
  } vga_if_t;

  // Offsets are taken modulo 64; outside the sprite box the value is
  // meaningless and is masked by the in-box flag downstream.
  function automatic logic [11:0] sprite_addr(input logic [10:0] cnt_h,
                                              input logic [10:0] cnt_v,
                                              input logic [11:0] pos_x,
                                              input logic [11:0] pos_y);
    logic [11:0] dx;
    logic [11:0] dy;
    dx = {1'b0, cnt_h} - pos_x;
    dy = {1'b0, cnt_v} - pos_y;
    return {dy[5:0], dx[5:0]};
  endfunction

endpackage

// File: rtl/signal_delay.sv
// ---------------------------------------------------------------------------
// signal_delay
// Generic shift pipeline with synchronous active-high reset. Every bit of
// i_din appears on o_dout exactly CLK_DEL clocks later; reset clears all
// stages so nothing stale leaks out after a flush.
//   i_clk  : clock
//   i_rst  : synchronous reset, active high
//   i_din  : WIDTH-bit input word
//   o_dout : WIDTH-bit word delayed by CLK_DEL clocks
// ---------------------------------------------------------------------------
module signal_delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  logic [WIDTH-1:0] r_pipe [CLK_DEL];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < CLK_DEL; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= i_din;
      for (int i = 1; i < CLK_DEL; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_dout = r_pipe[CLK_DEL-1];

endmodule

// File: rtl/draw_cat_sprite.sv
// ---------------------------------------------------------------------------
// draw_cat_sprite
// Overlays one animated 64x64 cat sprite on the VGA pixel stream.
//   Stage 1 : registers the ROM address and the in-box flag.
//   Stage 2 : the external ROM registers its four per-frame pixels; the VGA
//             bus and the in-box flag are delayed alongside.
//   Stage 3 : registers the overlaid bus (key colour is transparent).
// The animation FSM advances only on vsync rising edges, so the displayed
// frame never changes mid-frame.
//
// Handshake: there is none. Every input is consumed on every clock and every
// output is valid every clock; the ROM must return data exactly one clock
// after address.
//
// Ports
//   clk60MHz, rst                      : pixel clock, sync active-high reset
//   vcount_in, hcount_in (11)          : beam position
//   vsync_in, hsync_in, vblnk_in, hblnk_in : VGA timing
//   rgb_in (12)                        : background pixel
//   xpos, ypos (12)                    : sprite top-left corner
//   walking                            : animation enable, sampled at vsync edge
//   address (12)                       : ROM address {dy[5:0], dx[5:0]}
//   rom_rgb0..rom_rgb3 (12)            : ROM pixel per animation frame
//   *_out                              : VGA bus delayed by 3 clocks, overlaid
//   dbg_state                          : 1 while the animation FSM is in WALK
//   dbg_frame_disp (2)                 : animation frame currently displayed
// ---------------------------------------------------------------------------
module draw_cat_sprite #(
  parameter int          SPRITE_SIZE = cat_pkg::SPRITE_SIZE,
  parameter int          FRAME_HOLD  = 15,
  parameter logic [11:0] KEY_COLOR   = cat_pkg::KEY_COLOR
) (
  input  logic        clk60MHz,
  input  logic        rst,
  input  logic [10:0] vcount_in,
  input  logic [10:0] hcount_in,
  input  logic        vsync_in,
  input  logic        hsync_in,
  input  logic        vblnk_in,
  input  logic        hblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        walking,
  output logic [11:0] address,
  input  logic [11:0] rom_rgb0,
  input  logic [11:0] rom_rgb1,
  input  logic [11:0] rom_rgb2,
  input  logic [11:0] rom_rgb3,
  output logic [10:0] vcount_out,
  output logic [10:0] hcount_out,
  output logic        vsync_out,
  output logic        hsync_out,
  output logic        vblnk_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out,
  output logic        dbg_state,
  output logic [1:0]  dbg_frame_disp
);

  import cat_pkg::vga_if_t;
  import cat_pkg::anim_state_t;
  import cat_pkg::ST_IDLE;
  import cat_pkg::ST_WALK;

  localparam logic [7:0] HOLD_LAST  = 8'(FRAME_HOLD - 1);
  localparam logic [1:0] FRAME_LAST = 2'(cat_pkg::CAT_FRAMES - 1);

  // ---------------- input bus ----------------
  vga_if_t w_bus_in;
  vga_if_t w_bus2;
  vga_if_t r_out;

  assign w_bus_in.vcount = vcount_in;
  assign w_bus_in.hcount = hcount_in;
  assign w_bus_in.vsync  = vsync_in;
  assign w_bus_in.hsync  = hsync_in;
  assign w_bus_in.vblnk  = vblnk_in;
  assign w_bus_in.hblnk  = hblnk_in;
  assign w_bus_in.rgb    = rgb_in;

  // Timing bus rides two stages so it lines up with the ROM data.
  signal_delay #(
    .WIDTH   ($bits(vga_if_t)),
    .CLK_DEL (2)
  ) u_bus_delay (
    .i_clk  (clk60MHz),
    .i_rst  (rst),
    .i_din  (w_bus_in),
    .o_dout (w_bus2)
  );

  // ---------------- stage 1: address and box test ----------------
  // 13-bit compares so that xpos+SPRITE_SIZE cannot wrap; a sprite hanging
  // off the right edge is clipped rather than wrapped to column 0.
  logic [12:0] w_h13;
  logic [12:0] w_v13;
  logic [12:0] w_x13;
  logic [12:0] w_y13;
  logic        w_in_x;
  logic        w_in_y;
  logic        w_inbox0;

  assign w_h13    = {2'b00, hcount_in};
  assign w_v13    = {2'b00, vcount_in};
  assign w_x13    = {1'b0, xpos};
  assign w_y13    = {1'b0, ypos};
  assign w_in_x   = (w_h13 >= w_x13) && (w_h13 < w_x13 + 13'(SPRITE_SIZE));
  assign w_in_y   = (w_v13 >= w_y13) && (w_v13 < w_y13 + 13'(SPRITE_SIZE));
  assign w_inbox0 = w_in_x && w_in_y && !vblnk_in && !hblnk_in;

  logic [11:0] r_address;
  logic        r_inbox1;
  logic        r_inbox2;

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      r_address <= '0;
      r_inbox1  <= 1'b0;
      r_inbox2  <= 1'b0;
    end else begin
      r_address <= cat_pkg::sprite_addr(hcount_in, vcount_in, xpos, ypos);
      r_inbox1  <= w_inbox0;
      r_inbox2  <= r_inbox1;
    end
  end

  assign address = r_address;

  // ---------------- animation FSM ----------------
  anim_state_t r_state;
  logic [1:0]  r_frame;
  logic [1:0]  r_frame_disp;
  logic [7:0]  r_hold;
  logic        r_vsync_q;
  logic        w_vs_rise;
  logic [1:0]  w_frame_inc;

  assign w_vs_rise   = vsync_in & ~r_vsync_q;
  assign w_frame_inc = (r_frame == FRAME_LAST) ? 2'd0 : r_frame + 2'd1;

  // frame_disp is written together with frame, and only on a vsync edge,
  // so it always shows the frame chosen for the frame now starting.
  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_frame      <= '0;
      r_frame_disp <= '0;
      r_hold       <= '0;
      r_vsync_q    <= 1'b0;
    end else begin
      r_vsync_q <= vsync_in;
      if (w_vs_rise) begin
        case (r_state)
          ST_IDLE: begin
            r_frame      <= '0;
            r_frame_disp <= '0;
            r_hold       <= '0;
            if (walking) begin
              r_state <= ST_WALK;
            end
          end
          ST_WALK: begin
            if (!walking) begin
              r_state      <= ST_IDLE;
              r_frame      <= '0;
              r_frame_disp <= '0;
              r_hold       <= '0;
            end else if (r_hold == HOLD_LAST) begin
              r_hold       <= '0;
              r_frame      <= w_frame_inc;
              r_frame_disp <= w_frame_inc;
            end else begin
              r_hold       <= r_hold + 8'd1;
              r_frame_disp <= r_frame;
            end
          end
        endcase
      end
    end
  end

  assign dbg_state      = (r_state == ST_WALK);
  assign dbg_frame_disp = r_frame_disp;

  // ---------------- stage 3: overlay ----------------
  logic [11:0] w_sel;

  always_comb begin
    w_sel = rom_rgb0;
    case (r_frame_disp)
      2'd1:    w_sel = rom_rgb1;
      2'd2:    w_sel = rom_rgb2;
      2'd3:    w_sel = rom_rgb3;
      default: w_sel = rom_rgb0;
    endcase
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      r_out <= '0;
    end else begin
      r_out <= w_bus2;
      if (r_inbox2 && (w_sel != KEY_COLOR)) begin
        r_out.rgb <= w_sel;
      end
    end
  end

  assign vcount_out = r_out.vcount;
  assign hcount_out = r_out.hcount;
  assign vsync_out  = r_out.vsync;
  assign hsync_out  = r_out.hsync;
  assign vblnk_out  = r_out.vblnk;
  assign hblnk_out  = r_out.hblnk;
  assign rgb_out    = r_out.rgb;

endmodule

// File: tb/tb_draw_cat_sprite.sv
// ---------------------------------------------------------------------------
// tb_draw_cat_sprite
// Self-checking bench for draw_cat_sprite. A ROM model answers the DUT's
// address; a behavioural model predicts every output from the beam position,
// sprite box rules and a count of walking vsync edges.
// ---------------------------------------------------------------------------
module tb_draw_cat_sprite;

  localparam int          FH  = 2;
  localparam logic [11:0] KEY = 12'h0F0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [10:0] vcount_in = '0, hcount_in = '0;
  logic        vsync_in = 1'b0, hsync_in = 1'b0, vblnk_in = 1'b1, hblnk_in = 1'b1;
  logic [11:0] rgb_in = '0, xpos = '0, ypos = '0;
  logic        walking = 1'b0;
  logic [11:0] address;
  logic [11:0] rom_rgb0 = '0, rom_rgb1 = '0, rom_rgb2 = '0, rom_rgb3 = '0;
  logic [10:0] vcount_out, hcount_out;
  logic        vsync_out, hsync_out, vblnk_out, hblnk_out;
  logic [11:0] rgb_out;
  logic        dbg_state;
  logic [1:0]  dbg_frame_disp;

  draw_cat_sprite #(.FRAME_HOLD(FH), .KEY_COLOR(KEY)) dut (
    .clk60MHz(clk), .rst(rst),
    .vcount_in(vcount_in), .hcount_in(hcount_in),
    .vsync_in(vsync_in), .hsync_in(hsync_in), .vblnk_in(vblnk_in), .hblnk_in(hblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .walking(walking),
    .address(address),
    .rom_rgb0(rom_rgb0), .rom_rgb1(rom_rgb1), .rom_rgb2(rom_rgb2), .rom_rgb3(rom_rgb3),
    .vcount_out(vcount_out), .hcount_out(hcount_out),
    .vsync_out(vsync_out), .hsync_out(hsync_out), .vblnk_out(vblnk_out), .hblnk_out(hblnk_out),
    .rgb_out(rgb_out), .dbg_state(dbg_state), .dbg_frame_disp(dbg_frame_disp)
  );

  // ---------------- ROM model ----------------
  // 0: every pixel ABC, 1: per-frame pattern with some key pixels, 2: all key
  int rom_mode = 0;

  function automatic logic [11:0] rom_f(input int p, input logic [11:0] a);
    logic [1:0] pf;
    pf = 2'(p);
    if (rom_mode == 0) return 12'hABC;
    if (rom_mode == 2) return KEY;
    if (a[2:0] == 3'd5) return KEY;
    return {pf, a[9:0]} ^ 12'h501;
  endfunction

  always @(posedge clk) begin
    rom_rgb0 <= rom_f(0, address);
    rom_rgb1 <= rom_f(1, address);
    rom_rgb2 <= rom_f(2, address);
    rom_rgb3 <= rom_f(3, address);
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [37:0] got, input logic [37:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model of the animation: counts walking vsync edges.
  bit m_walk = 0;
  int m_cnt = 0;
  int m_disp = 0;
  bit m_prev_vs = 0;

  logic [37:0] exp_q[$];

  function automatic logic [11:0] addr_f(input int h, input int v, input int x, input int y);
    return 12'((((v - y) & 63) << 6) | ((h - x) & 63));
  endfunction

  function automatic logic [37:0] out_f(input int h, input int v, input int x, input int y,
                                        input logic vs, input logic hs, input logic vb,
                                        input logic hb, input logic [11:0] rgb, input int disp);
    bit          inbox;
    logic [11:0] pix;
    logic [11:0] col;
    inbox = (h >= x) && (h < x + 64) && (v >= y) && (v < y + 64) && !vb && !hb;
    pix = rom_f(disp, addr_f(h, v, x, y));
    col = (inbox && pix != KEY) ? pix : rgb;
    return {11'(v), 11'(h), vs, hs, vb, hb, col};
  endfunction

  always @(posedge clk) begin
    logic [11:0] exp_addr;
    if (rst) begin
      m_walk = 0; m_cnt = 0; m_disp = 0; m_prev_vs = 0;
      exp_q.delete();
      repeat (3) exp_q.push_back('0);
      exp_addr = '0;
    end else begin
      if (vsync_in && !m_prev_vs) begin
        if (!walking) begin
          m_walk = 0; m_cnt = 0; m_disp = 0;
        end else if (!m_walk) begin
          m_walk = 1; m_cnt = 0; m_disp = 0;
        end else begin
          m_cnt++;
          m_disp = (m_cnt / FH) % 4;
        end
      end
      m_prev_vs = vsync_in;
      exp_q.push_back(out_f(int'(hcount_in), int'(vcount_in), int'(xpos), int'(ypos),
                            vsync_in, hsync_in, vblnk_in, hblnk_in, rgb_in, m_disp));
      exp_addr = addr_f(int'(hcount_in), int'(vcount_in), int'(xpos), int'(ypos));
    end
    #1;
    if (exp_q.size() >= 3) begin
      check("vga_out", {vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out, rgb_out},
            exp_q.pop_front());
    end
    check("address", 38'(address), 38'(exp_addr));
    check("frame_disp", 38'(dbg_frame_disp), 38'(m_disp));
    check("state", 38'(dbg_state), 38'(m_walk));
  end

  // ---------------- driver tasks ----------------
  task automatic blank(input int n);
    repeat (n) begin
      @(negedge clk);
      vblnk_in = 1'b1; hblnk_in = 1'b1; vsync_in = 1'b0;
      hcount_in = 11'($urandom_range(0, 2047));
      vcount_in = 11'($urandom_range(0, 2047));
      rgb_in = 12'($urandom);
    end
  endtask

  task automatic rand_pixels(input int n, input int hlo, input int hhi, input int vlo, input int vhi);
    repeat (n) begin
      @(negedge clk);
      vblnk_in = 1'b0; vsync_in = 1'b0;
      hblnk_in = ($urandom_range(0, 7) == 0);
      hsync_in = 1'($urandom);
      hcount_in = 11'($urandom_range(hlo, hhi));
      vcount_in = 11'($urandom_range(vlo, vhi));
      rgb_in = 12'($urandom);
    end
  endtask

  task automatic vsync_pulse(input logic w);
    blank(2);
    @(negedge clk);
    vblnk_in = 1'b1; hblnk_in = 1'b1; vsync_in = 1'b1; walking = w;
    repeat (2) @(negedge clk);
    vsync_in = 1'b0;
    blank(4);
  endtask

  // Drive one beam position for three clocks, then check rgb_out literally.
  task automatic lit(input string name, input int h, input int v, input logic hb,
                     input logic [11:0] rgb, input logic [11:0] exp);
    @(negedge clk);
    hcount_in = 11'(h); vcount_in = 11'(v); hblnk_in = hb; vblnk_in = 1'b0;
    vsync_in = 1'b0; rgb_in = rgb;
    repeat (3) @(posedge clk);
    #1;
    check(name, 38'(rgb_out), 38'(exp));
  endtask

  function automatic int clip(input int a, input int lo, input int hi);
    return (a < lo) ? lo : ((a > hi) ? hi : a);
  endfunction

  // ---------------- main sequence ----------------
  int exp_disp_seq [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

  initial begin
    repeat (3) @(negedge clk);
    #2;
    check("reset_rgb", 38'(rgb_out), 38'h0);
    check("reset_addr", 38'(address), 38'h0);
    @(negedge clk);
    rst = 1'b0;
    blank(4);

    // Solid sprite at (100,50)
    xpos = 12'd100; ypos = 12'd50; rom_mode = 0;
    @(negedge clk);
    hcount_in = 11'd110; vcount_in = 11'd60; vblnk_in = 0; hblnk_in = 0; rgb_in = 12'h123;
    @(posedge clk); #1;
    check("addr_28A", 38'(address), 38'h28A);
    repeat (2) @(posedge clk); #1;
    check("in_box_ABC", 38'(rgb_out), 38'hABC);
    lit("left_edge_out", 99, 50, 1'b0, 12'h321, 12'h321);
    lit("left_edge_in", 100, 50, 1'b0, 12'h321, 12'hABC);
    lit("br_corner_in", 163, 113, 1'b0, 12'h456, 12'hABC);
    lit("right_edge_out", 164, 113, 1'b0, 12'h456, 12'h456);
    lit("bottom_out", 100, 114, 1'b0, 12'h789, 12'h789);
    lit("top_out", 100, 49, 1'b0, 12'h789, 12'h789);
    lit("hblank_in_box", 120, 70, 1'b1, 12'h5A5, 12'h5A5);
    rand_pixels(300, 90, 173, 40, 123);

    // Transparent key pixels
    blank(3); rom_mode = 2; blank(1);
    lit("key_transparent", 130, 80, 1'b0, 12'hEEE, 12'hEEE);
    rand_pixels(100, 90, 173, 40, 123);

    // Walking animation with per-frame patterns
    blank(3); rom_mode = 1; blank(1);
    for (int i = 0; i < 9; i++) begin
      vsync_pulse(1'b1);
      check("disp_seq", 38'(dbg_frame_disp), 38'(exp_disp_seq[i]));
      rand_pixels(120, 90, 173, 40, 123);
    end
    vsync_pulse(1'b0);
    check("walk_drop_disp", 38'(dbg_frame_disp), 38'h0);
    check("walk_drop_state", 38'(dbg_state), 38'h0);

    // Random positions with the animation running
    vsync_pulse(1'b1);
    for (int k = 0; k < 6; k++) begin
      blank(2);
      xpos = 12'($urandom_range(0, 900)); ypos = 12'($urandom_range(0, 700));
      rand_pixels(200, clip(int'(xpos) - 10, 0, 2047), clip(int'(xpos) + 73, 0, 2047),
                  clip(int'(ypos) - 10, 0, 2047), clip(int'(ypos) + 73, 0, 2047));
      vsync_pulse(1'b1);
    end

    // Sprite hanging off the right edge
    blank(3); rom_mode = 0; xpos = 12'd780; ypos = 12'd10; blank(1);
    lit("offscreen_h43", 43, 20, 1'b0, 12'h111, 12'h111);
    lit("offscreen_h0", 0, 20, 1'b0, 12'h222, 12'h222);
    lit("offscreen_h780", 780, 20, 1'b0, 12'h333, 12'hABC);
    lit("offscreen_h799", 799, 20, 1'b0, 12'h333, 12'hABC);
    blank(3); rom_mode = 1; blank(1);
    rand_pixels(400, 0, 799, 0, 90);

    // Reset in the middle of a line while walking
    xpos = 12'd100; ypos = 12'd50;
    vsync_pulse(1'b1);
    vsync_pulse(1'b1);
    vsync_pulse(1'b1);
    rand_pixels(20, 90, 173, 40, 123);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_rgb", 38'(rgb_out), 38'h0);
    check("rst_state", 38'(dbg_state), 38'h0);
    check("rst_frame", 38'(dbg_frame_disp), 38'h0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    rand_pixels(200, 90, 173, 40, 123);
    vsync_pulse(1'b1);
    rand_pixels(200, 90, 173, 40, 123);
    blank(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
